i2c_master_txn_ctl: RTL and testbench
=====================================

// Module: i2c_master_txn_ctl
// PURPOSE
//  Transaction sequencer above i2c_master_byte_ctl. Turns one request (7-bit addr, R/W, byte count)
//  into the byte-level command stream START, ADDR, ACK/NAK, data bytes, STOP. Streams write bytes
//  in and read bytes out, one byte per handshake. Reports done, NAK, arbitration-lost and timeout.
// PARAMETERS
//  LEN_W   8      width of byte-count request; max transfer = 2**LEN_W-1 bytes
//  TMO_W   20     width of per-command watchdog counter
//  TMO_MAX 20'hFFFFF  cycles waiting on i_cmd_ack before timeout abort
// PORTS
//  i_sysclk    in   1      system clock
//  i_nReset    in   1      asynchronous, active-low reset
//  i_enable    in   1      core enable; low = synchronous clear to IDLE
//  i_go        in   1      1-cycle request strobe, sampled only in IDLE
//  i_addr      in   7      slave address
//  i_rw        in   1      1=read, 0=write
//  i_len       in   LEN_W  data byte count (0 = address probe)
//  o_busy      out  1      transaction in progress
//  o_done      out  1      1-cycle pulse at end of every transaction (success or error)
//  o_nak       out  1      sticky: slave NAKed addr or data; cleared on next accepted i_go
//  o_al        out  1      sticky: arbitration lost; cleared on next accepted i_go
//  o_tmo       out  1      sticky: watchdog expired; cleared on next accepted i_go
//  o_tx_req    out  1      1-cycle pulse: i_tx_data consumed; next byte must be valid next cycle
//  i_tx_data   in   8      write byte; must be valid at i_go (first byte) and after each o_tx_req
//  o_rx_valid  out  1      1-cycle pulse: o_rx_data holds a new read byte
//  o_rx_data   out  8      last read byte, held until next o_rx_valid
//  o_cmd_trig  out  1      1-cycle command strobe to byte controller
//  o_cmd       out  4      command code (CMD_* from i2c-def.v)
//  o_wdata     out  8      byte to byte controller; held stable from trig until i_cmd_ack
//  i_cmd_ack   in   1      byte controller command complete
//  i_i2c_ack   in   1      sampled ACK bit after CMD_RD_ACK (0=ACK, 1=NAK)
//  i_i2c_al    in   1      arbitration lost
//  i_rdata     in   8      byte read, valid on i_cmd_ack of CMD_READ
// BEHAVIOUR
//  Reset/disable: state IDLE; all outputs 0, o_rx_data 8'h00, o_cmd CMD_IDLE, counters 0.
//  Every command state: o_cmd_trig high exactly one cycle on entry, then wait i_cmd_ack.
//  FSM (next state on i_cmd_ack unless noted):
//   IDLE     : i_go -> latch addr/rw/len, clear stickies, ->START. i_go outside IDLE ignored.
//   START    : CMD_START -> ADDR
//   ADDR     : CMD_WRITE, o_wdata={addr,rw} -> AACK
//   AACK     : CMD_RD_ACK; i_i2c_ack=1 -> set o_nak, ->STOP; len==0 -> STOP; rw ? RDATA : WDATA
//   WDATA    : CMD_WRITE, o_wdata=tx byte -> WACK
//   WACK     : CMD_RD_ACK; NAK -> o_nak, STOP; else cnt-1; cnt==0 -> STOP else o_tx_req, ->WDATA
//   RDATA    : CMD_READ -> capture i_rdata, o_rx_valid, ->RACK
//   RACK     : CMD_WR_ACK if cnt>1, CMD_WR_NAK on last byte; cnt-1; cnt==0 -> STOP else RDATA
//   STOP     : CMD_STOP -> DONE
//   DONE     : o_done pulse, ->IDLE (o_busy drops same cycle as o_done)
//  Tx byte: latched into o_wdata at i_go (first) and the cycle after each o_tx_req.
//  Counter cnt (LEN_W bits) loaded with i_len; decrement only after byte ACK phase; no wrap.
//  Arbitration lost (i_i2c_al=1 in any non-IDLE state): set o_al, no STOP issued, ->DONE.
//  Watchdog: reloads on every trig; reaching TMO_MAX -> set o_tmo, ->DONE (no STOP).
//  AL and i_cmd_ack in same cycle: AL wins. i_enable low mid-transfer: immediate IDLE, no o_done.
//  Async reset mid-transfer: all state cleared; bus recovery is software's responsibility.
// STRUCTURE
//  CMD_* codes from shared i2c-def.v; state encoding localparams local to this module.
//  Single FSM plus byte counter and watchdog; no sub-modules. Instantiates nothing; the parent
//  wraps this block and i2c_master_byte_ctl together.
// TESTING
//  Bench uses a behavioural byte-controller model (ack after N cycles, scripted ack/al/rdata).
//  1 Write addr 0x50, len 2, data A5,3C, all ACK -> cmds START,WRITE(A0),RD_ACK,WRITE(A5),
//    RD_ACK,WRITE(3C),RD_ACK,STOP; one o_tx_req; o_done, stickies 0.
//  2 Read addr 0x50, len 3, rdata 11,22,33 -> WRITE(A1), 3x READ, WR_ACK,WR_ACK,WR_NAK, STOP;
//    three o_rx_valid with 11,22,33.
//  3 Addr NAK (i_i2c_ack=1 after addr) -> STOP issued, no data cmds, o_nak=1, o_done pulse.
//  4 len=0 probe addr 0x3C -> START,WRITE(78),RD_ACK,STOP only.
//  5 i_i2c_al during 2nd data byte -> no STOP, o_al=1, o_done; next i_go clears o_al.
//  6 Model never acks (TMO_MAX=100) -> o_tmo after 100 cycles; i_go while busy ignored;
//    i_enable low mid-read -> IDLE, no o_done.

Source files
------------

// File: rtl/i2c_master_txn_ctl_pkg.sv
// Shared definitions for the I2C transaction sequencer: byte-controller
// command codes, the latched request record and a small command helper.
package i2c_master_txn_ctl_pkg;

  // Byte-controller command codes (same values as the shared i2c definitions)
  localparam logic [3:0] CMD_IDLE   = 4'd0;
  localparam logic [3:0] CMD_START  = 4'd1;
  localparam logic [3:0] CMD_STOP   = 4'd2;
  localparam logic [3:0] CMD_WRITE  = 4'd3;
  localparam logic [3:0] CMD_READ   = 4'd4;
  localparam logic [3:0] CMD_RD_ACK = 4'd5;
  localparam logic [3:0] CMD_WR_ACK = 4'd6;
  localparam logic [3:0] CMD_WR_NAK = 4'd7;

  // Address byte as it goes on the wire: {7-bit address, R/W}
  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
  } i2c_req_t;

  // Master acknowledge after a read byte: NAK the last one so the slave
  // releases SDA before STOP.
  function automatic logic [3:0] rack_cmd(input logic last_byte);
    if (last_byte) begin
      return CMD_WR_NAK;
    end else begin
      return CMD_WR_ACK;
    end
  endfunction

endpackage

// File: rtl/i2c_master_txn_ctl.sv
// I2C transaction sequencer: turns one request (addr, R/W, length) into the
// byte-level command stream for i2c_master_byte_ctl and streams data bytes.
module i2c_master_txn_ctl
  import i2c_master_txn_ctl_pkg::*;
#(
  parameter int               LEN_W   = 8,
  parameter int               TMO_W   = 20,
  parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
  input  logic             i_sysclk,
  input  logic             i_nReset,
  input  logic             i_enable,
  input  logic             i_go,
  input  logic [6:0]       i_addr,
  input  logic             i_rw,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nak,
  output logic             o_al,
  output logic             o_tmo,
  output logic             o_tx_req,
  input  logic [7:0]       i_tx_data,
  output logic             o_rx_valid,
  output logic [7:0]       o_rx_data,
  output logic             o_cmd_trig,
  output logic [3:0]       o_cmd,
  output logic [7:0]       o_wdata,
  input  logic             i_cmd_ack,
  input  logic             i_i2c_ack,
  input  logic             i_i2c_al,
  input  logic [7:0]       i_rdata
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_ADDR  = 4'd2;
  localparam logic [3:0] ST_AACK  = 4'd3;
  localparam logic [3:0] ST_WDATA = 4'd4;
  localparam logic [3:0] ST_WACK  = 4'd5;
  localparam logic [3:0] ST_RDATA = 4'd6;
  localparam logic [3:0] ST_RACK  = 4'd7;
  localparam logic [3:0] ST_STOP  = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_r;
  logic [3:0]       next_s;
  i2c_req_t         req_r;
  logic [LEN_W-1:0] cnt_r;
  logic [7:0]       tx_byte_r;
  logic [TMO_W-1:0] tmo_r;
  logic             tx_req_d_r;
  logic             is_cmd_s;
  logic             next_cmd_s;
  logic             fetch_s;
  logic             trig_s;
  logic [3:0]       cmd_s;
  logic [7:0]       wdata_s;
  logic             set_nak_s;
  logic             set_al_s;
  logic             set_tmo_s;
  logic             dec_s;
  logic             tx_req_s;
  logic             rx_cap_s;
  logic             go_s;

  // A later write byte is fetched over two cycles (o_tx_req, then latch) before its WRITE fires
  assign is_cmd_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign fetch_s  = (state_r == ST_WDATA) && (o_tx_req || tx_req_d_r);
  assign go_s     = (state_r == ST_IDLE) && i_go;

  // Next-state decode: arbitration loss beats everything, then watchdog, then command acks
  always_comb begin
    next_s    = state_r;
    set_nak_s = 1'b0;
    set_al_s  = 1'b0;
    set_tmo_s = 1'b0;
    dec_s     = 1'b0;
    tx_req_s  = 1'b0;
    rx_cap_s  = 1'b0;
    if (is_cmd_s && i_i2c_al) begin
      next_s   = ST_DONE;
      set_al_s = 1'b1;
    end else if (is_cmd_s && !fetch_s && !i_cmd_ack && (tmo_r == TMO_MAX)) begin
      next_s    = ST_DONE;
      set_tmo_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:  if (i_go) next_s = ST_START; else next_s = ST_IDLE;
        ST_START: if (i_cmd_ack) next_s = ST_ADDR; else next_s = state_r;
        ST_ADDR:  if (i_cmd_ack) next_s = ST_AACK; else next_s = state_r;
        ST_AACK: begin
          if (!i_cmd_ack) begin
            next_s = state_r;
          end else if (i_i2c_ack) begin
            next_s    = ST_STOP;
            set_nak_s = 1'b1;
          end else if (cnt_r == CNT_ZERO) begin
            next_s = ST_STOP;
          end else if (req_r.rw) begin
            next_s = ST_RDATA;
          end else begin
            next_s = ST_WDATA;
          end
        end
        ST_WDATA: if (i_cmd_ack && !fetch_s) next_s = ST_WACK; else next_s = state_r;
        ST_WACK: begin
          if (!i_cmd_ack) begin
            next_s = state_r;
          end else if (i_i2c_ack) begin
            next_s    = ST_STOP;
            set_nak_s = 1'b1;
          end else if (cnt_r <= CNT_ONE) begin
            next_s = ST_STOP;
            dec_s  = 1'b1;
          end else begin
            next_s   = ST_WDATA;
            dec_s    = 1'b1;
            tx_req_s = 1'b1;
          end
        end
        ST_RDATA: begin
          if (i_cmd_ack) begin
            next_s   = ST_RACK;
            rx_cap_s = 1'b1;
          end else begin
            next_s = state_r;
          end
        end
        ST_RACK: begin
          if (!i_cmd_ack) begin
            next_s = state_r;
          end else if (cnt_r <= CNT_ONE) begin
            next_s = ST_STOP;
            dec_s  = 1'b1;
          end else begin
            next_s = ST_RDATA;
            dec_s  = 1'b1;
          end
        end
        ST_STOP:  if (i_cmd_ack) next_s = ST_DONE; else next_s = state_r;
        ST_DONE:  next_s = ST_IDLE;
        default:  next_s = ST_IDLE;
      endcase
    end
  end

  // Command issue: strobe on entry to each command state (deferred for fetched write bytes)
  always_comb begin
    next_cmd_s = (next_s != ST_IDLE) && (next_s != ST_DONE);
    if ((state_r == ST_WDATA) && tx_req_d_r && (next_s == ST_WDATA)) begin
      trig_s = 1'b1;
    end else if ((next_s != state_r) && next_cmd_s &&
                 !((state_r == ST_WACK) && (next_s == ST_WDATA))) begin
      trig_s = 1'b1;
    end else begin
      trig_s = 1'b0;
    end
    case (next_s)
      ST_START: cmd_s = CMD_START;
      ST_ADDR:  cmd_s = CMD_WRITE;
      ST_AACK:  cmd_s = CMD_RD_ACK;
      ST_WDATA: cmd_s = CMD_WRITE;
      ST_WACK:  cmd_s = CMD_RD_ACK;
      ST_RDATA: cmd_s = CMD_READ;
      ST_RACK:  cmd_s = rack_cmd(cnt_r <= CNT_ONE);
      ST_STOP:  cmd_s = CMD_STOP;
      default:  cmd_s = CMD_IDLE;
    endcase
    if (state_r == ST_WDATA) begin
      wdata_s = i_tx_data;
    end else if (next_s == ST_ADDR) begin
      wdata_s = req_r;
    end else begin
      wdata_s = tx_byte_r;
    end
  end

  // Sequencer state, request latch, byte counter, first tx byte and watchdog
  always_ff @(posedge i_sysclk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_r    <= ST_IDLE;
      req_r      <= '{addr: 7'd0, rw: 1'b0};
      cnt_r      <= CNT_ZERO;
      tx_byte_r  <= 8'h00;
      tmo_r      <= {TMO_W{1'b0}};
      tx_req_d_r <= 1'b0;
    end else if (!i_enable) begin
      state_r    <= ST_IDLE;
      req_r      <= '{addr: 7'd0, rw: 1'b0};
      cnt_r      <= CNT_ZERO;
      tx_byte_r  <= 8'h00;
      tmo_r      <= {TMO_W{1'b0}};
      tx_req_d_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      tx_req_d_r <= o_tx_req;
      if (go_s) begin
        req_r     <= '{addr: i_addr, rw: i_rw};
        cnt_r     <= i_len;
        tx_byte_r <= i_tx_data;
      end else if (dec_s && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
      if (trig_s || fetch_s || !next_cmd_s) begin
        tmo_r <= {TMO_W{1'b0}};
      end else if (tmo_r != TMO_MAX) begin
        tmo_r <= tmo_r + TMO_ONE;
      end
    end
  end

  // Registered command interface towards the byte controller
  always_ff @(posedge i_sysclk or negedge i_nReset) begin
    if (!i_nReset) begin
      o_cmd_trig <= 1'b0;
      o_cmd      <= CMD_IDLE;
      o_wdata    <= 8'h00;
    end else if (!i_enable) begin
      o_cmd_trig <= 1'b0;
      o_cmd      <= CMD_IDLE;
      o_wdata    <= 8'h00;
    end else begin
      o_cmd_trig <= trig_s;
      if (trig_s) begin
        o_cmd   <= cmd_s;
        o_wdata <= wdata_s;
      end else if (!next_cmd_s) begin
        o_cmd <= CMD_IDLE;
      end
    end
  end

  // Status flags, data handshakes and the read-data holding register
  always_ff @(posedge i_sysclk or negedge i_nReset) begin
    if (!i_nReset) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_nak      <= 1'b0;
      o_al       <= 1'b0;
      o_tmo      <= 1'b0;
      o_tx_req   <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= 8'h00;
    end else if (!i_enable) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_nak      <= 1'b0;
      o_al       <= 1'b0;
      o_tmo      <= 1'b0;
      o_tx_req   <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= 8'h00;
    end else begin
      o_busy     <= next_cmd_s;
      o_done     <= (next_s == ST_DONE);
      o_nak      <= !go_s && (o_nak || set_nak_s);
      o_al       <= !go_s && (o_al || set_al_s);
      o_tmo      <= !go_s && (o_tmo || set_tmo_s);
      o_tx_req   <= tx_req_s;
      o_rx_valid <= rx_cap_s;
      if (rx_cap_s) begin
        o_rx_data <= i_rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_txn_ctl.sv
// Bench for i2c_master_txn_ctl: behavioural byte-controller responder with a
// command/read-data scoreboard, a table of transactions and corner sequences.
module tb_i2c_master_txn_ctl;
  import i2c_master_txn_ctl_pkg::*;

  logic       clk = 1'b0;
  logic       i_nReset, i_enable, i_go, i_rw;
  logic [6:0] i_addr;
  logic [7:0] i_len, i_tx_data, i_rdata;
  logic       i_cmd_ack, i_i2c_ack, i_i2c_al;
  logic       o_busy, o_done, o_nak, o_al, o_tmo, o_tx_req, o_rx_valid, o_cmd_trig;
  logic [7:0] o_rx_data, o_wdata;
  logic [3:0] o_cmd;

  always #5 clk = ~clk;

  i2c_master_txn_ctl #(.LEN_W(8), .TMO_W(20), .TMO_MAX(20'd100)) dut (
    .i_sysclk(clk), .i_nReset(i_nReset), .i_enable(i_enable), .i_go(i_go),
    .i_addr(i_addr), .i_rw(i_rw), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
    .o_nak(o_nak), .o_al(o_al), .o_tmo(o_tmo), .o_tx_req(o_tx_req), .i_tx_data(i_tx_data),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .o_cmd_trig(o_cmd_trig), .o_cmd(o_cmd),
    .o_wdata(o_wdata), .i_cmd_ack(i_cmd_ack), .i_i2c_ack(i_i2c_ack), .i_i2c_al(i_i2c_al),
    .i_rdata(i_rdata)
  );

  typedef struct packed { logic [3:0] cmd; logic [7:0] wdata; } exp_cmd_t;
  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  len;
    int          nak_at;   // index of RD_ACK answered with NAK (0 = address), -1 none
    logic [23:0] data;     // up to three bytes, first byte in the top bits
    logic        exp_nak;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_cmd_t   cmd_q[$];
  logic [7:0] rx_q[$];

  // responder script and observation state
  bit          sb_en = 1'b1;
  bit          rsp_noack = 1'b0;
  int          al_at = -1;
  int          nak_at = -1;
  int          trig_idx = 0;
  int          pend = -1;
  bit          pend_al = 1'b0;
  logic [3:0]  pend_cmd = CMD_IDLE;
  int          rdack_cnt = 0, rd_idx = 0, tx_idx = 0;
  int          tx_req_cnt = 0, rx_cnt = 0, done_cnt = 0;
  logic [23:0] cur_data = 24'h0;
  int          exp_tx = 0, exp_rx = 0;

  function automatic logic [7:0] byte_of(input logic [23:0] d, input int i);
    if (i >= 0 && i <= 2) return d[23-8*i -: 8];
    else return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural byte controller: acks each command 3 cycles after its strobe
  initial begin
    i_cmd_ack = 1'b0; i_i2c_ack = 1'b0; i_i2c_al = 1'b0; i_rdata = 8'h00;
    forever begin
      @(negedge clk);
      i_cmd_ack = 1'b0; i_i2c_ack = 1'b0; i_i2c_al = 1'b0;
      if (pend == 0) begin
        if (pend_al) begin
          i_i2c_al = 1'b1;
        end else begin
          i_cmd_ack = 1'b1;
          if (pend_cmd == CMD_RD_ACK) begin
            i_i2c_ack = (rdack_cnt == nak_at);
            rdack_cnt++;
          end
          if (pend_cmd == CMD_READ) begin
            i_rdata = byte_of(cur_data, rd_idx);
            rd_idx++;
          end
        end
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (o_cmd_trig) begin
        if (sb_en) begin
          chk("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
          if (cmd_q.size() != 0) begin
            exp_cmd_t e;
            e = cmd_q.pop_front();
            chk("cmd", 32'(o_cmd), 32'(e.cmd));
            if (e.cmd == CMD_WRITE) chk("wdata", 32'(o_wdata), 32'(e.wdata));
          end
        end
        if (!rsp_noack) begin
          pend     = 2;
          pend_cmd = o_cmd;
          pend_al  = (trig_idx == al_at);
        end
        trig_idx++;
      end
      if (o_tx_req) begin
        tx_req_cnt++;
        tx_idx++;
        i_tx_data = byte_of(cur_data, tx_idx);
      end
      if (o_rx_valid) begin
        rx_cnt++;
        if (sb_en) begin
          chk("rx_expected", 32'(rx_q.size() != 0), 32'd1);
          if (rx_q.size() != 0) chk("rx_data", 32'(o_rx_data), 32'(rx_q.pop_front()));
        end
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic push_cmd(input logic [3:0] c, input logic [7:0] w);
    exp_cmd_t e;
    e.cmd = c; e.wdata = w;
    cmd_q.push_back(e);
  endtask

  task automatic reset_script(input logic [23:0] d, input int nk);
    cur_data = d; nak_at = nk; al_at = -1; rsp_noack = 1'b0;
    rdack_cnt = 0; rd_idx = 0; tx_idx = 0; tx_req_cnt = 0; rx_cnt = 0; trig_idx = 0;
    cmd_q.delete(); rx_q.delete();
    exp_tx = 0; exp_rx = 0;
  endtask

  task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] len, input logic [7:0] d0);
    @(negedge clk);
    i_addr = a; i_rw = rw; i_len = len; i_tx_data = d0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    chk("busy_after_go", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_done(input int maxc, output bit seen);
    int n;
    n = 0;
    while (!o_done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    seen = o_done;
  endtask

  // Expected command stream for a well-behaved (no AL, no timeout) transaction
  task automatic build_expect(input vec_t v);
    push_cmd(CMD_START, 8'h00);
    push_cmd(CMD_WRITE, {v.addr, v.rw});
    push_cmd(CMD_RD_ACK, 8'h00);
    if (v.nak_at == 0 || v.len == 8'd0) begin
      push_cmd(CMD_STOP, 8'h00);
    end else if (v.rw) begin
      for (int i = 0; i < int'(v.len); i++) begin
        push_cmd(CMD_READ, 8'h00);
        rx_q.push_back(byte_of(v.data, i));
        exp_rx++;
        push_cmd((i == int'(v.len) - 1) ? CMD_WR_NAK : CMD_WR_ACK, 8'h00);
      end
      push_cmd(CMD_STOP, 8'h00);
    end else begin
      for (int i = 0; i < int'(v.len); i++) begin
        if (i > 0) exp_tx++;
        push_cmd(CMD_WRITE, byte_of(v.data, i));
        push_cmd(CMD_RD_ACK, 8'h00);
        if (v.nak_at == i + 1) break;
      end
      push_cmd(CMD_STOP, 8'h00);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    reset_script(v.data, v.nak_at);
    build_expect(v);
    launch(v.addr, v.rw, v.len, byte_of(v.data, 0));
    wait_done(2000, seen);
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    chk("nak", 32'(o_nak), 32'(v.exp_nak));
    chk("al", 32'(o_al), 32'd0);
    chk("tmo", 32'(o_tmo), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(o_done), 32'd0);
    chk("cmds_left", 32'(cmd_q.size()), 32'd0);
    chk("rx_left", 32'(rx_q.size()), 32'd0);
    chk("tx_req_count", 32'(tx_req_cnt), 32'(exp_tx));
    chk("rx_valid_count", 32'(rx_cnt), 32'(exp_rx));
  endtask

  vec_t vecs[5];
  vec_t probe;

  initial begin
    bit seen;
    int n, d0;
    vecs[0] = '{addr: 7'h50, rw: 1'b0, len: 8'd2, nak_at: -1, data: 24'hA53C00, exp_nak: 1'b0};
    vecs[1] = '{addr: 7'h50, rw: 1'b1, len: 8'd3, nak_at: -1, data: 24'h112233, exp_nak: 1'b0};
    vecs[2] = '{addr: 7'h50, rw: 1'b0, len: 8'd2, nak_at: 0,  data: 24'hA53C00, exp_nak: 1'b1};
    vecs[3] = '{addr: 7'h3C, rw: 1'b0, len: 8'd0, nak_at: -1, data: 24'h000000, exp_nak: 1'b0};
    vecs[4] = '{addr: 7'h2A, rw: 1'b0, len: 8'd2, nak_at: 1,  data: 24'h5AC300, exp_nak: 1'b1};
    probe   = '{addr: 7'h3C, rw: 1'b0, len: 8'd0, nak_at: -1, data: 24'h000000, exp_nak: 1'b0};

    i_nReset = 1'b0; i_enable = 1'b1; i_go = 1'b0; i_rw = 1'b0;
    i_addr = 7'h00; i_len = 8'h00; i_tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cmd", 32'(o_cmd), 32'(CMD_IDLE));
    chk("rst_trig", 32'(o_cmd_trig), 32'd0);
    chk("rst_rx_data", 32'(o_rx_data), 32'h00);
    chk("rst_flags", 32'({o_done, o_nak, o_al, o_tmo, o_tx_req, o_rx_valid}), 32'd0);
    i_nReset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Arbitration lost while the second data byte is on the bus
    reset_script(24'h112233, -1);
    al_at = 5;
    push_cmd(CMD_START, 8'h00);
    push_cmd(CMD_WRITE, 8'hA0);
    push_cmd(CMD_RD_ACK, 8'h00);
    push_cmd(CMD_WRITE, 8'h11);
    push_cmd(CMD_RD_ACK, 8'h00);
    push_cmd(CMD_WRITE, 8'h22);
    launch(7'h50, 1'b0, 8'd3, 8'h11);
    wait_done(2000, seen);
    chk("al_done_seen", 32'(seen), 32'd1);
    chk("al_flag", 32'(o_al), 32'd1);
    chk("al_nak", 32'(o_nak), 32'd0);
    repeat (20) @(negedge clk);
    chk("al_no_stop", 32'(trig_idx), 32'd6);
    chk("al_cmds_left", 32'(cmd_q.size()), 32'd0);
    chk("al_tx_req", 32'(tx_req_cnt), 32'd1);
    run_vec(probe);

    // Watchdog: byte controller never acks; an i_go while busy must be ignored
    reset_script(24'h0, -1);
    rsp_noack = 1'b1;
    push_cmd(CMD_START, 8'h00);
    launch(7'h11, 1'b0, 8'd0, 8'h00);
    chk("tmo_first_trig", 32'(o_cmd_trig), 32'd1);
    n = 0;
    while (!o_done && n < 500) begin
      @(negedge clk);
      n++;
      if (n == 10) begin i_addr = 7'h22; i_go = 1'b1; end
      if (n == 11) i_go = 1'b0;
    end
    chk("tmo_done_seen", 32'(o_done), 32'd1);
    chk("tmo_window", 32'(n >= 99 && n <= 103), 32'd1);
    chk("tmo_flag", 32'(o_tmo), 32'd1);
    chk("tmo_al", 32'(o_al), 32'd0);
    repeat (20) @(negedge clk);
    chk("tmo_go_ignored", 32'(trig_idx), 32'd1);
    chk("tmo_busy", 32'(o_busy), 32'd0);
    rsp_noack = 1'b0;
    run_vec(probe);

    // Enable dropped in the middle of a read: straight to idle, no o_done
    reset_script(24'h112233, -1);
    sb_en = 1'b0;
    launch(7'h50, 1'b1, 8'd3, 8'h00);
    n = 0;
    while (!o_rx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("en_rx_seen", 32'(o_rx_valid), 32'd1);
    @(negedge clk);
    i_enable = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("en_busy", 32'(o_busy), 32'd0);
    chk("en_cmd", 32'(o_cmd), 32'(CMD_IDLE));
    chk("en_rx_data", 32'(o_rx_data), 32'h00);
    repeat (10) @(negedge clk);
    chk("en_no_done", 32'(done_cnt - d0), 32'd0);
    i_enable = 1'b1;
    sb_en = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(probe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
